clk_div_ratio_ctrl: RTL
=======================

// Module: clk_div_ratio_ctrl
// PURPOSE
//  Arbitrates divide-ratio change requests from NUM_REQ clients.
//  Drives one shared integer clock divider (ratio + enable) in the clock-generation block.
//  Applies a new ratio only at a divider period boundary, then waits a settle window
//  before re-enabling the divider.
//  Completion is signalled with a one-cycle ack to the granted client.
// PARAMETERS
//  NUM_REQ     2  number of requesting clients (>=2)
//  RATIO_W     8  width of divide ratio
//  SETTLE_CYC  4  cycles divider is held disabled after a new ratio is loaded (>=1)
// PORTS
//  clk        in   1                 system clock, all logic on posedge
//  rst        in   1                 asynchronous, active-low reset
//  req        in   NUM_REQ           level request per client; hold until ack
//  req_ratio  in   NUM_REQ*RATIO_W   requested ratio; client i at [i*RATIO_W +: RATIO_W]
//  div_tick   in   1                 1-cycle pulse from divider at each output-clock period boundary
//  div_ratio  out  RATIO_W           ratio driven to divider
//  div_en     out  1                 divider enable
//  ack        out  NUM_REQ           one-hot 1-cycle completion pulse
//  busy       out  1                 high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=IDLE, div_ratio=0, div_en=0, ack=0, busy=0, rr pointer ptr=0.
//   - Reset mid-transaction aborts it; no ack is issued.
//  FSM states: IDLE, GRANT, DRAIN, LOAD, SETTLE, ACK.
//   IDLE
//    - Any req bit high -> GRANT.
//    - On the same edge, latch grant index g = first req bit at or after ptr (wrapping).
//    - On the same edge, latch lat_ratio = req_ratio[g].
//   GRANT
//    - If lat_ratio == div_ratio and div_en == (lat_ratio>=2): go to ACK (no divider disturbance).
//    - Otherwise go to DRAIN.
//   DRAIN
//    - If div_en==0: go to LOAD on the next edge.
//    - If div_en==1: wait for div_tick. On the edge sampling div_tick=1, set div_en<=0 and go to LOAD.
//    - div_tick is ignored in all other states.
//   LOAD
//    - div_ratio<=lat_ratio, cnt<=SETTLE_CYC-1, go to SETTLE.
//   SETTLE
//    - div_en held 0. If cnt==0 go to ACK, else cnt<=cnt-1.
//    - Exactly SETTLE_CYC cycles are spent in SETTLE.
//   ACK
//    - On entry, div_en<=(lat_ratio>=2); ratios 0 and 1 leave the divider disabled.
//    - While in ACK: ack[g]=1 for exactly one cycle.
//    - On the ACK->IDLE edge: ptr<=(g+1) mod NUM_REQ.
//  Latency (edges after the edge that samples req in IDLE):
//   - Same ratio: 1 edge to ACK.
//   - div_en=0: 3+SETTLE_CYC edges.
//   - div_en=1: DRAIN lasts until div_tick, then 1+SETTLE_CYC edges to ACK.
//  Request handling:
//   - A client dropping req after grant does not cancel the transaction; ack still pulses.
//   - req still high in IDLE after ack is a new request.
//   - Simultaneous requests are serviced one at a time in round-robin order.
//   - Non-granted req_ratio changes during a transaction are not sampled.
//  div_ratio changes only in LOAD, always while div_en==0. At most one ack bit is high per cycle.
// TESTING
//  1. Hold rst=0 with req=2'b11 -> div_ratio=0, div_en=0, ack=0, busy=0 throughout;
//     release rst, ack[0] arrives first.
//  2. After reset, req[0] with ratio 4, SETTLE_CYC=4 -> ack[0] 7 edges after req sampled;
//     div_ratio=4, div_en=1 from ACK on.
//  3. Repeat req[0] with ratio 4 -> ack[0] 1 edge after GRANT; div_en stays 1 with no gap.
//  4. req[1] ratio 6 while div_en=1, div_tick pulsed 10 cycles later ->
//     div_en=1 until tick edge, 0 for SETTLE, ack[1] 5 edges after tick edge, div_ratio=6.
//  5. req=2'b11 with ratios 3/5, ptr=0 -> ack[0] then ack[1], final div_ratio=5.
//     Repeat -> ack[0] first again (ptr wrapped).
//  6. req ratio 1 -> ack with div_ratio=1, div_en=0.
//     Separate run: assert rst during SETTLE -> immediate reset values, no ack.

Source files
------------

// File: rtl/clk_div_ratio_ctrl.sv
// Round-robin arbiter for divide-ratio change requests driving one shared clock divider.
// New ratios are loaded only at a divider period boundary, followed by a settle window.
module clk_div_ratio_ctrl #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned RATIO_W    = 8,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*RATIO_W-1:0] req_ratio,
    input  logic                       div_tick,
    output logic [RATIO_W-1:0]         div_ratio,
    output logic                       div_en,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StDrain,
        StLoad,
        StSettle,
        StAck
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   g_q;
    logic [RATIO_W-1:0] lat_ratio_q;
    logic [RATIO_W-1:0] div_ratio_q;
    logic               div_en_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [NUM_REQ-1:0] req_rot;
    logic [PTR_W-1:0]   pick;
    logic [RATIO_W-1:0] pick_ratio;
    logic               en_target;
    logic               same_cfg;

    // Rotate requests so bit 0 is the client at ptr; lowest set bit wins.
    always_comb begin
        req_rot    = NUM_REQ'({req, req} >> ptr_q);
        pick       = '0;
        pick_ratio = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick = PTR_W'((int'(ptr_q) + i) % int'(NUM_REQ));
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick == PTR_W'(i)) begin
                pick_ratio = req_ratio[i*RATIO_W +: RATIO_W];
            end
        end
    end

    // Ratios 0 and 1 leave the divider disabled.
    assign en_target = (lat_ratio_q >= RATIO_W'(2));
    assign same_cfg  = (lat_ratio_q == div_ratio_q) && (div_en_q == en_target);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (|req) state_d = StGrant;
            StGrant:  state_d = same_cfg ? StAck : StDrain;
            StDrain:  if (!div_en_q || div_tick) state_d = StLoad;
            StLoad:   state_d = StSettle;
            StSettle: if (cnt_q == '0) state_d = StAck;
            StAck:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            g_q         <= '0;
            lat_ratio_q <= '0;
            div_ratio_q <= '0;
            div_en_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req) begin
                        g_q         <= pick;
                        lat_ratio_q <= pick_ratio;
                    end
                end
                StDrain: begin
                    if (div_en_q && div_tick) div_en_q <= 1'b0;
                end
                StLoad: begin
                    div_ratio_q <= lat_ratio_q;
                    cnt_q       <= CNT_W'(SETTLE_CYC - 1);
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        div_en_q <= en_target;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StAck: begin
                    ptr_q <= (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack  = '0;
        busy = (state_q != StIdle);
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (state_q == StAck && g_q == PTR_W'(i)) ack[i] = 1'b1;
        end
    end

    assign div_ratio = div_ratio_q;
    assign div_en    = div_en_q;

endmodule
